shift_unit_iter: RTL and testbench
==================================

Name: shift_unit_iter

Overview:
- Parametrised, multi-cycle successor to the 64-bit combinational shift-left-by-one block.
- Shifts a WIDTH-bit operand by a run-time amount in one of four modes: SLL, SRL, SRA or ROL.
- Each cycle it shifts by up to STEP bits, trading latency for area; STEP=WIDTH gives a single-step barrel shifter.
- Sits beside the ALU and exchanges operands over valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 64, operand/result width in bits (power of two, ≥8).
- STEP, 1, maximum bits shifted per cycle (power of two, 1..WIDTH).
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  input operand valid.
- ready_o  output  1  unit can accept an operand.
- mode_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- shamt_i  input  SHAMT_W  shift amount, 0..WIDTH-1.
- data_i  input  WIDTH  operand.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- data_o  output  WIDTH  result, registered.

Behaviour:
- Reset: rst_i=1 at an edge forces state IDLE, valid_o=0, data_o=0, remaining count=0, latched mode=SLL. Reset overrides every other event, including mid-SHIFT and mid-DONE. The in-flight operation is discarded and no result is produced.
- ready_o = (state==IDLE) && !rst_i, combinational from state.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with valid_i && ready_o, capture data_i into the working register, and latch mode_i and shamt_i.
  - Next state is DONE if shamt_i==0, else SHIFT.
  - Inputs are ignored whenever ready_o=0.
- SHIFT:
  - Each edge shifts the working register by s = min(STEP, remaining) in the latched mode, then sets remaining -= s.
  - When the new remaining is 0, go to DONE.
- DONE:
  - valid_o=1; data_o = working register.
  - On an edge with ready_i=1, go to IDLE and clear valid_o.
  - While ready_i=0, data_o and valid_o hold stable.
  - No new operand is accepted in the same cycle as result handoff; throughput is one op per ceil(k/STEP)+2 cycles minimum.
- Latency: for shift amount k, valid_o rises ceil(k/STEP)+1 cycles after the acceptance cycle. k=0 gives 1 cycle.
- Arithmetic rules:
  - SLL and SRL zero-fill.
  - SRA replicates the operand MSB (bit WIDTH-1 of the original operand) on every step.
  - ROL wraps bits from MSB into LSB.
  - Results are exactly equal to a single shift by k; no dependence on STEP.
- data_o is registered and changes only when entering DONE or on reset. It is not cleared on return to IDLE.
- shamt_i is unsigned. Values of WIDTH and above are not representable, so there is no out-of-range case.

Decomposition:
- Package shift_unit_pkg holds:
  - mode encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROL=2'b11;
  - the FSM state enum (IDLE, SHIFT, DONE).
- One sub-module, shift_step: a combinational single-step shifter taking operand, mode and amount (0..STEP) and returning the shifted value.
- The top level holds only the FSM, the counter and the registers.

Test Plan:
- WIDTH=64, STEP=1, SLL, data 0x0000_0000_0000_0001, shamt 1 -> valid_o at acceptance+2, data_o=0x0000_0000_0000_0002.
- STEP=1, SRA, data 0x8000_0000_0000_0000, shamt 4 -> valid_o at acceptance+5, data_o=0xF800_0000_0000_0000. The same operand with SRL gives 0x0800_0000_0000_0000.
- ROL, data 0x8000_0000_0000_0001, shamt 1 -> data_o=0x0000_0000_0000_0003. With shamt 0, data passes through with valid_o at acceptance+1.
- STEP=4, SLL, data 0x1, shamt 7 -> exactly 2 SHIFT cycles, valid_o at acceptance+3, data_o=0x80.
- Backpressure in DONE: hold ready_i=0 for 3 cycles while driving valid_i=1 with a new operand -> data_o and valid_o stable, ready_o=0, new operand not captured. Raise ready_i -> IDLE next cycle, then the new operand is accepted.
- Assert rst_i for one cycle mid-SHIFT (STEP=1, shamt 10, 3 cycles in) -> next cycle valid_o=0, data_o=0, ready_o=1, and no result ever emitted for that op.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// Shared definitions for the iterative shift unit.
//   - Mode encodings driven on mode_i.
//   - FSM state type used by shift_unit_iter.
package shift_unit_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter used by shift_unit_iter.
// Ports:
//   data   - operand to shift (WIDTH bits)
//   mode   - SH_SLL / SH_SRL / SH_SRA / SH_ROL
//   amt    - shift amount for this step, 0..WIDTH ($clog2(WIDTH)+1 bits)
//   result - shifted operand
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] result
);

  localparam logic [AMT_W-1:0] FULL = AMT_W'(WIDTH);

  always_comb begin
    result = data;
    case (mode)
      SH_SLL: result = data << amt;
      SH_SRL: result = data >> amt;
      // An arithmetic right shift never changes the MSB, so filling from the
      // current MSB on every step replicates the original operand's MSB.
      SH_SRA: result = $signed(data) >>> amt;
      // amt=0 makes the right shift go by WIDTH, which yields zero.
      SH_ROL: result = (data << amt) | (data >> (FULL - amt));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: SLL / SRL / SRA / ROL of a WIDTH-bit operand by a
// run-time amount, up to STEP bits per cycle, valid/ready on both sides.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   valid_i, ready_o  - operand handshake (mode_i, shamt_i, data_i)
//   valid_o, ready_i  - result handshake (data_o, registered)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand, ready_o high
// SHIFT | shifting working register by min(STEP, remaining) per cycle
// DONE  | result presented on data_o, waiting for ready_i
module shift_unit_iter
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         mode_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   data_o
);

  // One extra bit so that STEP=WIDTH is representable.
  localparam int AMT_W = SHAMT_W + 1;
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_t             state, state_next;
  logic [WIDTH-1:0]   work, work_next, step_out;
  logic [1:0]         mode_q;
  logic [SHAMT_W-1:0] remaining, remaining_next;
  logic [AMT_W-1:0]   rem_a, step_amt;
  logic               accept;

  assign ready_o  = (state == IDLE) && !rst_i;
  assign valid_o  = (state == DONE);
  assign accept   = valid_i && ready_o;
  assign rem_a    = {1'b0, remaining};
  assign step_amt = (rem_a > STEP_A) ? STEP_A : rem_a;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (work),
    .mode   (mode_q),
    .amt    (step_amt),
    .result (step_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    work_next      = work;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (accept) begin
          work_next      = data_i;
          remaining_next = shamt_i;
          state_next     = (shamt_i == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_next = step_out;
        // step_amt never exceeds remaining, so its MSB is zero here.
        remaining_next = remaining - step_amt[SHAMT_W-1:0];
        if (remaining_next == '0) state_next = DONE;
      end
      DONE: begin
        if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      work      <= '0;
      mode_q    <= SH_SLL;
      remaining <= '0;
      data_o    <= '0;
    end else begin
      work      <= work_next;
      remaining <= remaining_next;
      if (accept) mode_q <= mode_i;
      // data_o only moves on entry to DONE; it keeps the last result in IDLE.
      if (state_next == DONE && state != DONE) data_o <= work_next;
    end
  end

endmodule

// File: tb/tb_shift_unit_iter.sv
module tb_shift_unit_iter;

  localparam int W = 64;
  localparam logic [1:0] M_SLL = 2'b00, M_SRL = 2'b01, M_SRA = 2'b10, M_ROL = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i [2];
  logic       ready_i [2];
  logic [1:0] mode_i  [2];
  logic [5:0] shamt_i [2];
  logic [W-1:0] data_i [2];
  logic       ready_o [2];
  logic       valid_o [2];
  logic [W-1:0] data_o [2];

  int steps [2] = '{1, 4};
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  shift_unit_iter #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .mode_i(mode_i[0]), .shamt_i(shamt_i[0]), .data_i(data_i[0]),
    .valid_o(valid_o[0]), .ready_i(ready_i[0]), .data_o(data_o[0]));

  shift_unit_iter #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .mode_i(mode_i[1]), .shamt_i(shamt_i[1]), .data_i(data_i[1]),
    .valid_o(valid_o[1]), .ready_i(ready_i[1]), .data_o(data_o[1]));

  task automatic chk(input string name, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Reference: a single shift by k, straight from the arithmetic definitions.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input int k, input logic [W-1:0] d);
    logic [W-1:0] ones;
    ones = '1;
    case (m)
      M_SLL: return d << k;
      M_SRL: return d >> k;
      M_SRA: return d[W-1] ? ((d >> k) | ~(ones >> k)) : (d >> k);
      default: return (d << k) | (d >> (W - k));
    endcase
  endfunction

  // Transaction-level model: result due ceil(k/STEP)+1 cycles after acceptance.
  bit           m_valid    [2];
  bit           m_inflight [2];
  int           m_wait     [2];
  logic [W-1:0] m_result   [2];
  logic [W-1:0] m_data     [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_valid[d] = 0; m_inflight[d] = 0; m_data[d] = '0;
      end else if (m_valid[d]) begin
        if (ready_i[d]) m_valid[d] = 0;
      end else if (m_inflight[d]) begin
        m_wait[d]--;
        if (m_wait[d] == 0) begin
          m_valid[d] = 1; m_data[d] = m_result[d]; m_inflight[d] = 0;
        end
      end else if (valid_i[d]) begin
        m_result[d] = ref_shift(mode_i[d], int'(shamt_i[d]), data_i[d]);
        m_wait[d]   = (int'(shamt_i[d]) + steps[d] - 1) / steps[d];
        if (m_wait[d] == 0) begin
          m_valid[d] = 1; m_data[d] = m_result[d];
        end else begin
          m_inflight[d] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("ready_o", d, W'(ready_o[d]), W'(!rst && !m_valid[d] && !m_inflight[d]));
        chk("valid_o", d, W'(valid_o[d]), W'(m_valid[d]));
        chk("data_o",  d, data_o[d], m_data[d]);
      end
    end
  end

  task automatic run_op(input string name, input int d, input logic [1:0] m, input int k,
                        input logic [W-1:0] din, input logic [W-1:0] exp, input int exp_lat);
    bit ok;
    int n;
    ok = 0;
    @(negedge clk);
    valid_i[d] = 1; mode_i[d] = m; shamt_i[d] = 6'(k); data_i[d] = din;
    for (int i = 0; i < 200; i++) begin
      if (ready_o[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    chk({name, " accept"}, d, W'(ok), W'(1));
    @(posedge clk);
    #1 valid_i[d] = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (valid_o[d]) break;
    end
    chk({name, " latency"}, d, W'(n), W'(exp_lat));
    chk({name, " data"}, d, data_o[d], exp);
  endtask

  initial begin
    int n;
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      valid_i[d] = 0; ready_i[d] = 1; mode_i[d] = 0; shamt_i[d] = 0; data_i[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset ready", d, W'(ready_o[d]), W'(1));
      chk("reset valid", d, W'(valid_o[d]), W'(0));
      chk("reset data",  d, data_o[d], '0);
    end

    // STEP=1
    run_op("sll1",   0, M_SLL, 1,  64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 2);
    run_op("sra4",   0, M_SRA, 4,  64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000, 5);
    run_op("srl4",   0, M_SRL, 4,  64'h8000_0000_0000_0000, 64'h0800_0000_0000_0000, 5);
    run_op("rol1",   0, M_ROL, 1,  64'h8000_0000_0000_0001, 64'h0000_0000_0000_0003, 2);
    run_op("rol0",   0, M_ROL, 0,  64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1);
    run_op("sra63",  0, M_SRA, 63, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run_op("sll63",  0, M_SLL, 63, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64);

    // STEP=4
    run_op("s4 sll7",  1, M_SLL, 7,  64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, 3);
    run_op("s4 sra4",  1, M_SRA, 4,  64'h8000_0000_0000_0000, 64'hF800_0000_0000_0000, 2);
    run_op("s4 srl5",  1, M_SRL, 5,  64'hFF00_0000_0000_0000, 64'h07F8_0000_0000_0000, 3);
    run_op("s4 rol63", 1, M_ROL, 63, 64'h8000_0000_0000_0001, 64'hC000_0000_0000_0000, 17);
    run_op("s4 sll0",  1, M_SLL, 0,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1);

    // Backpressure in DONE with a competing operand on the input.
    ready_i[0] = 0;
    run_op("bp first", 0, M_SLL, 2, 64'h5, 64'h14, 3);
    valid_i[0] = 1; mode_i[0] = M_SRL; shamt_i[0] = 6'd1; data_i[0] = 64'hF0;
    repeat (3) begin
      @(negedge clk);
      chk("bp ready", 0, W'(ready_o[0]), W'(0));
      chk("bp valid", 0, W'(valid_o[0]), W'(1));
      chk("bp data",  0, data_o[0], 64'h14);
    end
    ready_i[0] = 1;
    @(negedge clk);
    chk("bp release ready", 0, W'(ready_o[0]), W'(1));
    chk("bp release hold",  0, data_o[0], 64'h14);
    @(posedge clk);
    #1 valid_i[0] = 0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (valid_o[0]) break;
    end
    chk("bp second latency", 0, W'(n), W'(2));
    chk("bp second data",    0, data_o[0], 64'h78);

    // Reset in the middle of a long shift.
    run_op("pre rst", 0, M_ROL, 3, 64'h1, 64'h8, 4);
    @(negedge clk);
    valid_i[0] = 1; mode_i[0] = M_SLL; shamt_i[0] = 6'd10; data_i[0] = 64'h1;
    for (int i = 0; i < 20; i++) begin
      if (ready_o[0]) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 valid_i[0] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst valid", 0, W'(valid_o[0]), W'(0));
    chk("rst data",  0, data_o[0], '0);
    chk("rst ready", 0, W'(ready_o[0]), W'(1));
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid_o[0]) n++;
    end
    chk("rst no result", 0, W'(n), W'(0));

    run_op("post rst", 0, M_SRL, 3, 64'h80, 64'h10, 4);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
